// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: default register-file geometry and the
// register dump reader FSM state encoding.
package cpu_pkg;

  localparam int WIDTH_DEF    = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int ADDR_W_DEF   = 5;

  // CSUM is only reachable when the checksum trailer is built in.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    SEND = 3'd2,
    CSUM = 3'd3,
    FIN  = 3'd4
  } state_e;

endpackage

// File: rtl/regdump_range_ctr.sv
// Index walker for the register dump reader. It holds the current register
// index and the number of words still to be emitted. The index wraps
// naturally at NUM_REGS because NUM_REGS is a power of two.
module regdump_range_ctr
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] first_idx,
  input  logic [ADDR_W-1:0] last_idx,
  output logic [ADDR_W-1:0] cur,
  output logic [ADDR_W-1:0] next_idx,
  output logic              last
);

  logic [ADDR_W-1:0] cur_r;
  logic [ADDR_W:0]   rem_r;
  logic [ADDR_W-1:0] span_s;
  logic [ADDR_W:0]   load_cnt_s;

  // Word count for a load: modular span plus one, so that equal indices
  // give a single word and a 0..NUM_REGS-1 range gives a full dump.
  always_comb begin
    span_s     = last_idx - first_idx;
    load_cnt_s = {1'b0, span_s} + {{ADDR_W{1'b0}}, 1'b1};
  end

  // Current index and remaining word count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_r <= {ADDR_W{1'b0}};
      rem_r <= {(ADDR_W+1){1'b0}};
    end else if (load) begin
      cur_r <= first_idx;
      rem_r <= load_cnt_s;
    end else if (step) begin
      rem_r <= rem_r - {{ADDR_W{1'b0}}, 1'b1};
      if (!last) begin
        cur_r <= next_idx;
      end
    end
  end

  assign cur      = cur_r;
  assign next_idx = cur_r + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign last     = (rem_r == {{ADDR_W{1'b0}}, 1'b1});

endmodule

// File: rtl/regfile_dump_reader.sv
// Register file dump reader. On start it walks an index range through one
// register-file read port and streams every value out on a valid/ready
// port, one word per READ+SEND pair. It never writes the register file.
// Optional build macro REGDUMP_CHECKSUM_EN appends an XOR checksum word
// (m_is_csum=1, m_index=0) after the data words; without it m_is_csum is 0
// and m_last marks the final data word.
module regfile_dump_reader
  import cpu_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_idx,
  input  logic [ADDR_W-1:0] end_idx,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WIDTH-1:0]  m_data,
  output logic [ADDR_W-1:0] m_index,
  output logic              m_last,
  output logic              m_is_csum
);

  state_e            state_r;
  state_e            state_nx_s;
  logic              start_acc_s;
  logic              data_hs_s;
  logic [ADDR_W-1:0] cur_s;
  logic [ADDR_W-1:0] next_idx_s;
  logic              last_s;

  logic              busy_r;
  logic              done_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic              m_valid_r;
  logic [WIDTH-1:0]  m_data_r;
  logic [ADDR_W-1:0] m_index_r;
  logic              m_last_r;

`ifdef REGDUMP_CHECKSUM_EN
  logic [WIDTH-1:0]  acc_r;
  logic              m_is_csum_r;
`endif

  regdump_range_ctr #(
    .ADDR_W (ADDR_W)
  ) u_range_ctr (
    .clk       (clk),
    .rst       (rst),
    .load      (start_acc_s),
    .step      (data_hs_s),
    .first_idx (start_idx),
    .last_idx  (end_idx),
    .cur       (cur_s),
    .next_idx  (next_idx_s),
    .last      (last_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic plus the start-accept and data-handshake strobes.
  always_comb begin
    state_nx_s  = state_r;
    start_acc_s = 1'b0;
    data_hs_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          start_acc_s = 1'b1;
          state_nx_s  = READ;
        end else begin
          state_nx_s  = IDLE;
        end
      end
      READ: begin
        state_nx_s = SEND;
      end
      SEND: begin
        if (m_valid_r && m_ready) begin
          data_hs_s = 1'b1;
          if (last_s) begin
`ifdef REGDUMP_CHECKSUM_EN
            state_nx_s = CSUM;
`else
            state_nx_s = FIN;
`endif
          end else begin
            state_nx_s = READ;
          end
        end else begin
          state_nx_s = SEND;
        end
      end
`ifdef REGDUMP_CHECKSUM_EN
      CSUM: begin
        if (m_valid_r && m_ready) begin
          state_nx_s = FIN;
        end else begin
          state_nx_s = CSUM;
        end
      end
`endif
      FIN: begin
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Registered status, read address and stream word; the word is captured
  // at the READ edge and held untouched until its handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      rd_addr_r   <= {ADDR_W{1'b0}};
      m_valid_r   <= 1'b0;
      m_data_r    <= {WIDTH{1'b0}};
      m_index_r   <= {ADDR_W{1'b0}};
      m_last_r    <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      m_is_csum_r <= 1'b0;
`endif
    end else begin
      busy_r <= (state_nx_s != IDLE);
      done_r <= (state_nx_s == FIN);
      case (state_r)
        IDLE: begin
          if (start_acc_s) begin
            rd_addr_r <= start_idx;
          end
        end
        READ: begin
          m_data_r  <= rd_data;
          m_index_r <= cur_s;
`ifdef REGDUMP_CHECKSUM_EN
          m_last_r  <= 1'b0;
`else
          m_last_r  <= last_s;
`endif
          m_valid_r <= 1'b1;
        end
        SEND: begin
          if (data_hs_s) begin
            m_valid_r <= 1'b0;
            if (!last_s) begin
              rd_addr_r <= next_idx_s;
            end
          end
        end
`ifdef REGDUMP_CHECKSUM_EN
        CSUM: begin
          // First CSUM cycle presents the trailer; it then waits for accept.
          if (!m_valid_r) begin
            m_data_r    <= acc_r;
            m_index_r   <= {ADDR_W{1'b0}};
            m_last_r    <= 1'b1;
            m_is_csum_r <= 1'b1;
            m_valid_r   <= 1'b1;
          end else if (m_ready) begin
            m_valid_r   <= 1'b0;
            m_is_csum_r <= 1'b0;
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

`ifdef REGDUMP_CHECKSUM_EN
  // Running XOR of accepted data words, cleared when a dump is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r <= {WIDTH{1'b0}};
    end else if (start_acc_s) begin
      acc_r <= {WIDTH{1'b0}};
    end else if (data_hs_s) begin
      acc_r <= acc_r ^ m_data_r;
    end
  end

  assign m_is_csum = m_is_csum_r;
`else
  assign m_is_csum = 1'b0;
`endif

  assign busy    = busy_r;
  assign done    = done_r;
  assign rd_addr = rd_addr_r;
  assign m_valid = m_valid_r;
  assign m_data  = m_data_r;
  assign m_index = m_index_r;
  assign m_last  = m_last_r;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader with a scoreboard of expected
// stream words built from the bench's own register-file contents.
module tb_regfile_dump_reader;

  localparam int W  = 32;
  localparam int N  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_idx;
  logic [AW-1:0] end_idx;
  logic          busy;
  logic          done;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  m_data;
  logic [AW-1:0] m_index;
  logic          m_last;
  logic          m_is_csum;

  logic [W-1:0]  rf [N];

  typedef struct packed {
    logic [W-1:0]  data;
    logic [AW-1:0] idx;
    logic          last;
    logic          csum;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   last_hs_cyc = -10;

  regfile_dump_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .start_idx (start_idx),
    .end_idx   (end_idx),
    .busy      (busy),
    .done      (done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_index   (m_index),
    .m_last    (m_last),
    .m_is_csum (m_is_csum)
  );

  assign rd_data = rf[rd_addr];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: a handshake is due at the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_word", W'(m_index), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("word_data", m_data, e.data);
        check("word_index", W'(m_index), W'(e.idx));
        check("word_last", W'(m_last), W'(e.last));
        check("word_csum", W'(m_is_csum), W'(e.csum));
      end
      last_hs_cyc = cyc;
    end
    if (done) begin
      check("done_timing", cyc, last_hs_cyc + 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input logic [AW-1:0] s, input logic [AW-1:0] e);
    logic [AW-1:0] idx;
    logic [AW-1:0] span;
    int            n;
    exp_t          x;
`ifdef REGDUMP_CHECKSUM_EN
    logic [W-1:0]  acc;
    acc = 32'h0;
`endif
    span = e - s;
    n    = int'(span) + 1;
    idx  = s;
    for (int i = 0; i < n; i++) begin
      x.data = rf[idx];
      x.idx  = idx;
      x.csum = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      x.last = 1'b0;
      acc    = acc ^ rf[idx];
`else
      x.last = (i == n - 1);
`endif
      sb.push_back(x);
      idx = idx + 5'd1;
    end
`ifdef REGDUMP_CHECKSUM_EN
    x.data = acc;
    x.idx  = 5'd0;
    x.last = 1'b1;
    x.csum = 1'b1;
    sb.push_back(x);
`endif
  endtask

  task automatic start_dump(input logic [AW-1:0] s, input logic [AW-1:0] e);
    push_range(s, e);
    start     = 1'b1;
    start_idx = s;
    end_idx   = e;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 300 && !done; k++) tick();
    check({tag, "_done_seen"}, W'(done), 32'h1);
    tick();
    check({tag, "_done_pulse"}, W'(done), 32'h0);
    check({tag, "_busy_after"}, W'(busy), 32'h0);
    check({tag, "_sb_empty"}, W'(sb.size()), 32'h0);
  endtask

  task automatic wait_valid(input string tag);
    for (int k = 0; k < 50 && !m_valid; k++) tick();
    check({tag, "_valid"}, W'(m_valid), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    start_idx = 5'd0;
    end_idx   = 5'd0;
    m_ready   = 1'b0;
    for (int i = 0; i < N; i++) rf[i] = 32'h100 + i;
    rf[0] = 32'h0;
    for (int i = 1; i <= 9; i++) rf[i] = i;
    rf[10] = 32'h10;
    rf[11] = 32'h14;
    rf[12] = 32'h19;
    rf[13] = 32'h14;
    tick(); tick(); tick();

    // Reset state
    check("rst_busy", W'(busy), 32'h0);
    check("rst_done", W'(done), 32'h0);
    check("rst_valid", W'(m_valid), 32'h0);
    check("rst_rd_addr", W'(rd_addr), 32'h0);
    check("rst_m_data", m_data, 32'h0);
    check("rst_m_index", W'(m_index), 32'h0);
    check("rst_m_last", W'(m_last), 32'h0);
    check("rst_m_is_csum", W'(m_is_csum), 32'h0);
    rst = 1'b0;
    tick();

    // Basic dump 1..3 with m_ready held high
    m_ready = 1'b1;
    start_dump(5'd1, 5'd3);
    check("t1_busy", W'(busy), 32'h1);
    check("t1_rd_addr", W'(rd_addr), 32'h1);
    check("t1_valid_in_read", W'(m_valid), 32'h0);
    tick();
    check("t1_first_valid", W'(m_valid), 32'h1);
    wait_done("t1");

    // Wrap through index 0
    start_dump(5'd30, 5'd1);
    wait_done("t2");

    // Backpressure: five stalled cycles per word
    m_ready = 1'b0;
    start_dump(5'd10, 5'd12);
    for (int w = 0; w < 3; w++) begin
      wait_valid("t3");
      for (int k = 0; k < 5; k++) begin
        tick();
        check("t3_hold_valid", W'(m_valid), 32'h1);
        check("t3_hold_data", m_data, rf[10 + w]);
        check("t3_hold_index", W'(m_index), W'(10 + w));
      end
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
    end
    m_ready = 1'b1;
    wait_done("t3");

    // Reset in the middle of the idx 11 word
    start_dump(5'd10, 5'd12);
    for (int k = 0; k < 50 && !(m_valid && m_index == 5'd11); k++) tick();
    check("t4_reached_idx11", W'(m_index), 32'd11);
    #2;
    rst = 1'b1;
    #1;
    check("t4_valid_drop", W'(m_valid), 32'h0);
    check("t4_busy_drop", W'(busy), 32'h0);
    check("t4_done_low", W'(done), 32'h0);
    sb.delete();
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("t4_no_done", W'(done), 32'h0);
    start_dump(5'd13, 5'd13);
    wait_done("t4");

    // Start while busy is ignored; write to R5 on its READ edge
    start_dump(5'd4, 5'd6);
    start     = 1'b1;
    start_idx = 5'd20;
    end_idx   = 5'd21;
    tick();
    start     = 1'b0;
    for (int k = 0; k < 50 && !(busy && !m_valid && rd_addr == 5'd5); k++) tick();
    check("t5_read5", W'(rd_addr), 32'd5);
    @(posedge clk);
    rf[5] <= 32'hAA;
    #1;
    wait_done("t5");
    tick();
    check("t5_idle", W'(busy), 32'h0);
    start_dump(5'd5, 5'd5);
    wait_done("t5b");

    // Dump 11..12 (checksum 0x0D when the trailer is built in)
    start_dump(5'd11, 5'd12);
    wait_done("t6");

    // Full dump 0..31
    start_dump(5'd0, 5'd31);
    wait_done("t7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Debug/trace reader for the CPU register file.
- On command, walks an index range through one register-file read port and streams each register value out over a valid/ready interface.
- Sits beside the datapath and drives the read-address mux during debug/halt. It is the consumer of register contents that writeback produces.
- Strictly non-intrusive: no write access.

Parameters:
- WIDTH, 32, data word width (matches register file).
- NUM_REGS, 32, register count; must be a power of two.
- ADDR_W, 5, index width, log2(NUM_REGS).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin dump; sampled only in IDLE
- start_idx  input  ADDR_W  first register index, latched on start accept
- end_idx  input  ADDR_W  last register index, latched on start accept
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse after the final handshake
- rd_addr  output  ADDR_W  to register-file read port (registered)
- rd_data  input  WIDTH  combinational read data from register file
- m_valid  output  1  stream word valid
- m_ready  input  1  downstream accept
- m_data  output  WIDTH  register value (or checksum)
- m_index  output  ADDR_W  index of m_data
- m_last  output  1  final word of dump
- m_is_csum  output  1  word is checksum (tied 0 without feature)

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values: all outputs 0; state IDLE; internal counters 0. Reset mid-dump aborts immediately; m_valid drops asynchronously; there is no partial done.
- FSM states: IDLE, READ, SEND, CSUM (feature only), FIN.
- IDLE:
  - start=1: latch start_idx/end_idx; cur<=start_idx; rd_addr<=start_idx; remaining<=((end_idx-start_idx) mod NUM_REGS)+1 (ADDR_W+1 bits); go READ.
  - start=0: stay.
- READ (rd_addr==cur, stable):
  - m_data<=rd_data; m_index<=cur; m_last<=(remaining==1) and feature off; m_valid<=1; go SEND.
- SEND:
  - Hold m_data/m_index/m_last stable while m_valid && !m_ready.
  - On handshake: m_valid<=0; remaining-=1.
  - If remaining was 1: go CSUM if feature on, else FIN.
  - Otherwise: cur<=cur+1 (wraps NUM_REGS-1 -> 0); rd_addr<=cur+1; go READ.
- FIN: done=1 for this cycle only; go IDLE.
- Latency and throughput:
  - First m_valid is 2 cycles after the start edge.
  - One word per 2 cycles at best (READ+SEND).
  - done is 1 cycle after the last handshake.
- Range rules:
  - start_idx==end_idx: single word.
  - end_idx<start_idx: wraps through index 0.
  - start_idx=0,end_idx=NUM_REGS-1: full dump of NUM_REGS words.
- Index 0 is emitted as whatever rd_data returns (register file forces 0).
- Snapshot semantics are per word: the value is sampled at the READ edge. A writeback to the same register on that edge yields the pre-write value. Later words see updated contents.
- start while busy: ignored, not queued. start_idx/end_idx changes mid-dump: ignored.
- m_ready asserted with m_valid low: no effect.

Optional Feature:
- Macro REGDUMP_CHECKSUM_EN.
- Defined:
  - Running XOR accumulator, cleared on start accept; each data word is XORed in at its handshake.
  - After the last data word, state CSUM presents m_data=accumulator, m_index=0, m_is_csum=1, m_last=1, with the same handshake rule. Handshake -> FIN.
  - Data words carry m_last=0.
- Undefined: no accumulator or CSUM state; m_is_csum tied 0; m_last on the final data word.

Decomposition:
- Shared package cpu_pkg: WIDTH/NUM_REGS/ADDR_W defaults; FSM state enum (IDLE, READ, SEND, CSUM, FIN).
- Optional sub-module regdump_range_ctr: cur/remaining wrap counter with load/step/last outputs. Everything else stays in one module.

Test Plan:
- Register file preloaded (R1..R9=1..9, R10=0x10, R11=0x14, R12=0x19, R13=0x14), start_idx=1, end_idx=3, m_ready=1 -> words (1,1),(2,2),(3,3); m_last on idx 3; done pulse 1 cycle after; busy low afterward.
- Wrap: start_idx=30, end_idx=1 -> m_index sequence 30,31,0,1; idx 0 data 0x0; exactly 4 handshakes.
- Backpressure: start_idx=10, end_idx=12, m_ready low 5 cycles per word -> m_data/m_index held stable; words 0x10,0x14,0x19 in order; no loss or duplication.
- Reset mid-dump: assert rst during SEND of idx 11 -> m_valid, busy, done 0 immediately; new start 13..13 -> single word 0x14 with m_last.
- start pulsed while busy, plus regfile write to R5=0xAA in the same cycle the reader samples idx 5 in a 4..6 dump -> second start ignored; idx 5 emits 0x5; a later dump of idx 5 emits 0xAA.
- REGDUMP_CHECKSUM_EN defined, dump 1..3 -> 3 data words with m_last=0, then checksum 0x0 (1^2^3) with m_is_csum=1, m_last=1. Dump 11..12 -> checksum 0x0D.
